soc_addr_decoder_rt: RTL and testbench
======================================

SOC_ADDR_DECODER_RT -- requirements
Module: soc_addr_decoder_rt

Interface
REQ-001 The block SHALL have parameter NumRules, default 14 (NB_PERIPHERALS), meaning the number of address rules.
REQ-002 The block SHALL have parameter AddrWidth, default 64, meaning the lookup and rule address width.
REQ-003 The block SHALL have parameter DefaultRules, default the SoC peripheral map (Debug..HYAXI, end = Base+Length), meaning the rule contents loaded at reset.
REQ-004 The block SHALL have these ports, one per line:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  reset; one clock, and reset is synchronous and active-low.
- cfg_req_i  in  1  config access request.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_addr_i  in  $clog2(NumRules)+2  {rule, field}; field 0 = start, 1 = end, 2 = idx, 3 = enable.
- cfg_wdata_i  in  64  write data.
- cfg_gnt_o  out  1  access accepted.
- cfg_rvalid_o  out  1  response valid.
- cfg_rdata_o  out  64  read data.
- cfg_err_o  out  1  access rejected.
- cfg_lock_i  in  1  sticky map lock.
- req_valid_i  in  1  lookup request valid.
- req_ready_o  out  1  lookup request ready.
- req_addr_i  in  AddrWidth  lookup address.
- rsp_valid_o  out  1  lookup result valid.
- rsp_ready_i  in  1  lookup result ready.
- rsp_idx_o  out  32  matched slave index.
- rsp_decerr_o  out  1  no rule matched.
- miss_cnt_o  out  16  decode-miss count.

Function
REQ-005 Each rule SHALL hit when enable=1 and start_addr <= addr < end_addr (unsigned compare; end is exclusive).
REQ-006 A rule with start_addr >= end_addr SHALL never hit.
REQ-007 On multiple hits, the lowest rule number SHALL win.
REQ-008 On no hit, the response SHALL be rsp_decerr_o=1 with rsp_idx_o=0.
REQ-009 Lookup SHALL use one registered stage: the result is presented on rsp_* one cycle after the req_valid_i && req_ready_o handshake.
REQ-010 req_ready_o SHALL equal !rsp_valid_o || rsp_ready_i (full throughput, no bubble).
REQ-011 rsp_* SHALL hold stable while rsp_valid_o && !rsp_ready_i.
REQ-012 cfg_gnt_o SHALL equal cfg_req_i.
REQ-013 cfg_rvalid_o SHALL pulse exactly one cycle after each grant.
REQ-014 cfg_rdata_o SHALL return the field value; idx reads are zero-extended and enable reads return bit0.
REQ-015 Writes SHALL take effect at the granting clock edge.
REQ-016 A lookup handshaked in the same cycle as a config write SHALL decode with the pre-write rules.
REQ-017 The lock SHALL be set by cfg_lock_i=1 and cleared only by reset.
REQ-018 While locked, writes SHALL be dropped and flagged with cfg_err_o=1 alongside cfg_rvalid_o; reads stay legal.
REQ-019 A config access to a rule number >= NumRules SHALL return cfg_err_o=1 and rdata 0, and SHALL not write.
REQ-020 miss_cnt_o SHALL increment on each accepted lookup that results in decerr and SHALL saturate at 16'hFFFF.

Reset
REQ-021 On reset, the rules SHALL load DefaultRules with all enables set to 1.
REQ-022 On reset, rsp_valid_o, cfg_rvalid_o, cfg_err_o and the lock SHALL be 0; rsp_idx_o, rsp_decerr_o, cfg_rdata_o and miss_cnt_o SHALL be 0.
REQ-023 A reset asserted while a response is pending SHALL drop that response without a handshake.

Configuration
REQ-024 With SOC_ADDR_MAP_OVERLAP_CHECK_EN defined, a write that leaves any two enabled rules with overlapping non-empty ranges, or start > end, SHALL be rejected with cfg_err_o=1 and the registers SHALL stay unchanged.
REQ-025 The overlap check SHALL be performed on the candidate map in the granting cycle.
REQ-026 Without SOC_ADDR_MAP_OVERLAP_CHECK_EN, every unlocked in-range write SHALL be accepted and REQ-007 resolves overlaps.

Structure
REQ-027 addr_map_rule_t, the Base/Length constants and the default-map constant SHALL live in the shared ariane_soc package.
REQ-028 Per-rule match logic SHALL be the sub-module soc_addr_rule_match, instantiated NumRules times; the priority encode and registers stay in the top.

Verification
REQ-029 Default map, lookup 0x4000_0FFF then 0x4000_1000 -> rsp_idx_o=10 with decerr=0, then decerr=1, and miss_cnt_o=1.
REQ-030 Lookup 0x8000_0000 with rsp_ready_i held low for 3 cycles -> rsp_idx_o=13 held stable, req_ready_o=0, and the next request is accepted in the cycle after rsp_ready_i=1.
REQ-031 Write rule 10 start to 0x5000_0000, with a lookup of 0x4000_0000 in the same cycle -> that lookup gives idx 10, and the next lookup of 0x4000_0000 gives decerr.
REQ-032 Assert cfg_lock_i, then write rule 1 end -> cfg_err_o=1 and a readback gives 0x0002_0000.
REQ-033 With SOC_ADDR_MAP_OVERLAP_CHECK_EN, write rule 7 (Timer) start to 0x1C00_0000 -> cfg_err_o=1 and the rule is unchanged; without the macro the write is accepted and 0x1C00_0000 decodes to idx 5.
REQ-034 Drive 65540 miss lookups -> miss_cnt_o=0xFFFF, then reset mid-response -> rsp_valid_o=0 and miss_cnt_o=0 on the next cycle.

Source files
------------

// File: rtl/soc_addr_decoder_rt_pkg.sv
// Shared SoC address-map types, peripheral Base/Length constants and the reset-time default map.
package ariane_soc;

  localparam int unsigned NbPeripherals = 14;

  typedef struct packed {
    logic [31:0] idx;
    logic [63:0] start_addr;
    logic [63:0] end_addr;
  } addr_map_rule_t;

  localparam logic [63:0] DebugBase    = 64'h0000_0000;
  localparam logic [63:0] DebugLength  = 64'h0000_1000;
  localparam logic [63:0] RomBase      = 64'h0001_0000;
  localparam logic [63:0] RomLength    = 64'h0001_0000;
  localparam logic [63:0] ClintBase    = 64'h0200_0000;
  localparam logic [63:0] ClintLength  = 64'h000C_0000;
  localparam logic [63:0] PlicBase     = 64'h0C00_0000;
  localparam logic [63:0] PlicLength   = 64'h0400_0000;
  localparam logic [63:0] UartBase     = 64'h1000_0000;
  localparam logic [63:0] UartLength   = 64'h0000_1000;
  localparam logic [63:0] SramBase     = 64'h1C00_0000;
  localparam logic [63:0] SramLength   = 64'h0040_0000;
  localparam logic [63:0] SpiBase      = 64'h2000_0000;
  localparam logic [63:0] SpiLength    = 64'h0080_0000;
  localparam logic [63:0] TimerBase    = 64'h1800_0000;
  localparam logic [63:0] TimerLength  = 64'h0000_1000;
  localparam logic [63:0] EthernetBase   = 64'h3000_0000;
  localparam logic [63:0] EthernetLength = 64'h0001_0000;
  localparam logic [63:0] GpioBase     = 64'h3100_0000;
  localparam logic [63:0] GpioLength   = 64'h0000_1000;
  localparam logic [63:0] CtrlBase     = 64'h4000_0000;
  localparam logic [63:0] CtrlLength   = 64'h0000_1000;
  localparam logic [63:0] ApbBase      = 64'h4100_0000;
  localparam logic [63:0] ApbLength    = 64'h0000_1000;
  localparam logic [63:0] DramBase     = 64'h6000_0000;
  localparam logic [63:0] DramLength   = 64'h2000_0000;
  localparam logic [63:0] HyaxiBase    = 64'h8000_0000;
  localparam logic [63:0] HyaxiLength  = 64'h4000_0000;

  function automatic addr_map_rule_t mk_rule(input int unsigned idx, input logic [63:0] base,
                                             input logic [63:0] len);
    addr_map_rule_t r;
    r.idx        = 32'(idx);
    r.start_addr = base;
    r.end_addr   = base + len;
    return r;
  endfunction

  function automatic addr_map_rule_t [NbPeripherals-1:0] gen_default_map();
    addr_map_rule_t [NbPeripherals-1:0] m;
    m[0]  = mk_rule(0, DebugBase, DebugLength);
    m[1]  = mk_rule(1, RomBase, RomLength);
    m[2]  = mk_rule(2, ClintBase, ClintLength);
    m[3]  = mk_rule(3, PlicBase, PlicLength);
    m[4]  = mk_rule(4, UartBase, UartLength);
    m[5]  = mk_rule(5, SramBase, SramLength);
    m[6]  = mk_rule(6, SpiBase, SpiLength);
    m[7]  = mk_rule(7, TimerBase, TimerLength);
    m[8]  = mk_rule(8, EthernetBase, EthernetLength);
    m[9]  = mk_rule(9, GpioBase, GpioLength);
    m[10] = mk_rule(10, CtrlBase, CtrlLength);
    m[11] = mk_rule(11, ApbBase, ApbLength);
    m[12] = mk_rule(12, DramBase, DramLength);
    m[13] = mk_rule(13, HyaxiBase, HyaxiLength);
    return m;
  endfunction

  localparam addr_map_rule_t [NbPeripherals-1:0] DefaultMap = gen_default_map();

endpackage

// File: rtl/soc_addr_rule_match.sv
// Single address-rule comparator: hit when enabled and start <= addr < end (end exclusive).
module soc_addr_rule_match #(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-1:0] start_i,
  input  logic [AddrWidth-1:0] end_i,
  input  logic                 en_i,
  output logic                 hit_o
);

  // start >= end is an empty range and can never hit.
  assign hit_o = en_i && (start_i < end_i) && (addr_i >= start_i) && (addr_i < end_i);

endmodule

// File: rtl/soc_addr_decoder_rt.sv
// Runtime-configurable address decoder with a registered lookup stage and lockable rule map.
// Optional feature: SOC_ADDR_MAP_OVERLAP_CHECK_EN rejects writes that create overlapping rules.
module soc_addr_decoder_rt
  import ariane_soc::*;
#(
  parameter int unsigned                     NumRules     = NbPeripherals,
  parameter int unsigned                     AddrWidth    = 64,
  parameter addr_map_rule_t [NumRules-1:0]   DefaultRules = DefaultMap
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_req_i,
  input  logic                          cfg_we_i,
  input  logic [$clog2(NumRules)+1:0]   cfg_addr_i,
  input  logic [63:0]                   cfg_wdata_i,
  output logic                          cfg_gnt_o,
  output logic                          cfg_rvalid_o,
  output logic [63:0]                   cfg_rdata_o,
  output logic                          cfg_err_o,
  input  logic                          cfg_lock_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [AddrWidth-1:0]          req_addr_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [31:0]                   rsp_idx_o,
  output logic                          rsp_decerr_o,
  output logic [15:0]                   miss_cnt_o
);

  localparam int unsigned RuleW = $clog2(NumRules);

  logic [RuleW-1:0] cfg_rule;
  logic [1:0]       cfg_field;
  logic             cfg_in_range, cfg_wr_req, cfg_wr_ok, overlap_err;

  logic [NumRules-1:0][63:0] start_q, start_d, end_q, end_d;
  logic [NumRules-1:0][31:0] idx_q, idx_d;
  logic [NumRules-1:0]       en_q, en_d;
  logic                      lock_q, lock_d;

  logic        cfg_rvalid_q, cfg_err_q, cfg_err_d;
  logic [63:0] cfg_rdata_q, cfg_rdata_d;

  logic [NumRules-1:0] hit;
  logic                any_hit, req_hs;
  logic [31:0]         hit_idx;
  logic                rsp_valid_q, rsp_valid_d, rsp_decerr_q, rsp_decerr_d;
  logic [31:0]         rsp_idx_q, rsp_idx_d;
  logic [15:0]         miss_q, miss_d;

  assign cfg_rule     = cfg_addr_i[RuleW+1:2];
  assign cfg_field    = cfg_addr_i[1:0];
  assign cfg_in_range = 32'(cfg_rule) < NumRules;
  assign cfg_wr_req   = cfg_req_i & cfg_we_i & cfg_in_range;
  assign cfg_wr_ok    = cfg_wr_req & ~lock_q & ~overlap_err;
  assign lock_d       = lock_q | cfg_lock_i;

  // Candidate map: current rules with the requested write applied; committed only if legal.
  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    idx_d   = idx_q;
    en_d    = en_q;
    if (cfg_wr_req) begin
      case (cfg_field)
        2'd0:    start_d[cfg_rule] = cfg_wdata_i;
        2'd1:    end_d[cfg_rule]   = cfg_wdata_i;
        2'd2:    idx_d[cfg_rule]   = cfg_wdata_i[31:0];
        default: en_d[cfg_rule]    = cfg_wdata_i[0];
      endcase
    end
  end

`ifdef SOC_ADDR_MAP_OVERLAP_CHECK_EN
  always_comb begin
    overlap_err = 1'b0;
    for (int i = 0; i < int'(NumRules); i++) begin
      if (en_d[i] && (start_d[i] > end_d[i])) overlap_err = 1'b1;
      for (int j = i + 1; j < int'(NumRules); j++) begin
        if (en_d[i] && en_d[j] && (start_d[i] < end_d[i]) && (start_d[j] < end_d[j]) &&
            (start_d[i] < end_d[j]) && (start_d[j] < end_d[i])) begin
          overlap_err = 1'b1;
        end
      end
    end
  end
`else
  assign overlap_err = 1'b0;
`endif

  always_comb begin
    cfg_rdata_d = '0;
    if (cfg_req_i && !cfg_we_i && cfg_in_range) begin
      case (cfg_field)
        2'd0:    cfg_rdata_d = start_q[cfg_rule];
        2'd1:    cfg_rdata_d = end_q[cfg_rule];
        2'd2:    cfg_rdata_d = {32'b0, idx_q[cfg_rule]};
        default: cfg_rdata_d = {63'b0, en_q[cfg_rule]};
      endcase
    end
  end

  assign cfg_err_d = cfg_req_i & (~cfg_in_range | (cfg_we_i & (lock_q | overlap_err)));

  for (genvar i = 0; i < NumRules; i++) begin : g_match
    soc_addr_rule_match #(
      .AddrWidth (AddrWidth)
    ) u_match (
      .addr_i  (req_addr_i),
      .start_i (start_q[i][AddrWidth-1:0]),
      .end_i   (end_q[i][AddrWidth-1:0]),
      .en_i    (en_q[i]),
      .hit_o   (hit[i])
    );
  end

  // Walk from the top so the lowest-numbered hit is the last assignment and wins.
  always_comb begin
    hit_idx = '0;
    any_hit = 1'b0;
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = idx_q[i];
        any_hit = 1'b1;
      end
    end
  end

  assign req_ready_o = ~rsp_valid_q | rsp_ready_i;
  assign req_hs      = req_valid_i & req_ready_o;

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_idx_d    = rsp_idx_q;
    rsp_decerr_d = rsp_decerr_q;
    miss_d       = miss_q;
    if (req_hs) begin
      rsp_valid_d  = 1'b1;
      rsp_idx_d    = any_hit ? hit_idx : 32'd0;
      rsp_decerr_d = ~any_hit;
      if (!any_hit && (miss_q != 16'hFFFF)) miss_d = miss_q + 16'd1;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumRules); i++) begin
        start_q[i] <= DefaultRules[i].start_addr;
        end_q[i]   <= DefaultRules[i].end_addr;
        idx_q[i]   <= DefaultRules[i].idx;
      end
      en_q         <= '1;
      lock_q       <= 1'b0;
      cfg_rvalid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_rdata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_idx_q    <= '0;
      rsp_decerr_q <= 1'b0;
      miss_q       <= '0;
    end else begin
      if (cfg_wr_ok) begin
        start_q <= start_d;
        end_q   <= end_d;
        idx_q   <= idx_d;
        en_q    <= en_d;
      end
      lock_q       <= lock_d;
      cfg_rvalid_q <= cfg_req_i;
      cfg_err_q    <= cfg_err_d;
      cfg_rdata_q  <= cfg_rdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_idx_q    <= rsp_idx_d;
      rsp_decerr_q <= rsp_decerr_d;
      miss_q       <= miss_d;
    end
  end

  assign cfg_gnt_o    = cfg_req_i;
  assign cfg_rvalid_o = cfg_rvalid_q;
  assign cfg_err_o    = cfg_err_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_idx_o    = rsp_idx_q;
  assign rsp_decerr_o = rsp_decerr_q;
  assign miss_cnt_o   = miss_q;

endmodule

// File: tb/tb_soc_addr_decoder_rt.sv
// Scoreboard bench for soc_addr_decoder_rt: directed lookups and config accesses on the default map.
module tb_soc_addr_decoder_rt;

  localparam int unsigned NumRules = 14;
  localparam int unsigned CfgAW    = $clog2(NumRules) + 2;
`ifdef SOC_ADDR_MAP_OVERLAP_CHECK_EN
  localparam bit OverlapChk = 1'b1;
`else
  localparam bit OverlapChk = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              cfg_req_i = 1'b0, cfg_we_i = 1'b0, cfg_lock_i = 1'b0;
  logic [CfgAW-1:0]  cfg_addr_i = '0;
  logic [63:0]       cfg_wdata_i = '0;
  logic              cfg_gnt_o, cfg_rvalid_o, cfg_err_o;
  logic [63:0]       cfg_rdata_o;
  logic              req_valid_i = 1'b0, req_ready_o;
  logic [63:0]       req_addr_i = '0;
  logic              rsp_valid_o, rsp_ready_i = 1'b1, rsp_decerr_o;
  logic [31:0]       rsp_idx_o;
  logic [15:0]       miss_cnt_o;

  soc_addr_decoder_rt u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_req_i    (cfg_req_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_gnt_o    (cfg_gnt_o),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .cfg_err_o    (cfg_err_o),
    .cfg_lock_i   (cfg_lock_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_idx_o    (rsp_idx_o),
    .rsp_decerr_o (rsp_decerr_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] idx;
    logic        decerr;
  } rsp_exp_t;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [63:0] rdata;
  } cfg_exp_t;

  rsp_exp_t    rsp_q[$];
  cfg_exp_t    cfg_q[$];
  rsp_exp_t    mon_rsp;
  cfg_exp_t    mon_cfg;
  int          checks = 0;
  int          failures = 0;
  int unsigned exp_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake / config response.
  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got idx 0x%0h with no expectation queued", rsp_idx_o);
      end else begin
        mon_rsp = rsp_q.pop_front();
        check("rsp_idx", 64'(rsp_idx_o), 64'(mon_rsp.idx));
        check("rsp_decerr", 64'(rsp_decerr_o), 64'(mon_rsp.decerr));
      end
    end
    if (rst_ni && cfg_rvalid_o) begin
      if (cfg_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cfg_unexpected: got rvalid with no expectation queued");
      end else begin
        mon_cfg = cfg_q.pop_front();
        check("cfg_err", 64'(cfg_err_o), 64'(mon_cfg.err));
        if (mon_cfg.chk) check("cfg_rdata", cfg_rdata_o, mon_cfg.rdata);
      end
    end
  end

  task automatic lookup(input logic [63:0] addr, input logic [31:0] e_idx, input logic e_dec);
    int n = 0;
    rsp_q.push_back('{idx: e_idx, decerr: e_dec});
    if (e_dec && exp_miss < 32'hFFFF) exp_miss++;
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    @(negedge clk_i);
    while (!req_ready_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    if (!req_ready_o) begin
      checks++;
      failures++;
      $display("FAIL lookup_timeout: got req_ready_o=0 expected 1 within 50 cycles");
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic cfg(input logic we, input int unsigned rule, input int unsigned field,
                     input logic [63:0] wdata, input logic e_err, input logic e_chk,
                     input logic [63:0] e_rdata);
    cfg_q.push_back('{err: e_err, chk: e_chk, rdata: e_rdata});
    cfg_req_i   = 1'b1;
    cfg_we_i    = we;
    cfg_addr_i  = CfgAW'(rule * 4 + field);
    cfg_wdata_i = wdata;
    @(negedge clk_i);
    check("cfg_gnt", 64'(cfg_gnt_o), 64'd1);
    @(posedge clk_i);
    #1;
    cfg_req_i = 1'b0;
    cfg_we_i  = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_miss(input string name);
    @(negedge clk_i);
    check(name, 64'(miss_cnt_o), 64'(exp_miss));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_idx", 64'(rsp_idx_o), 64'd0);
    check("rst_rsp_decerr", 64'(rsp_decerr_o), 64'd0);
    check("rst_cfg_rvalid", 64'(cfg_rvalid_o), 64'd0);
    check("rst_cfg_err", 64'(cfg_err_o), 64'd0);
    check("rst_cfg_rdata", cfg_rdata_o, 64'd0);
    check("rst_miss", 64'(miss_cnt_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1;

    // Exclusive end of rule 10 and start boundaries.
    lookup(64'h4000_0FFF, 32'd10, 1'b0);
    lookup(64'h4000_1000, 32'd0, 1'b1);
    wait_idle();
    chk_miss("miss_after_first");
    lookup(64'h0000_0000, 32'd0, 1'b0);
    lookup(64'h0000_0FFF, 32'd0, 1'b0);
    lookup(64'h0001_0000, 32'd1, 1'b0);
    lookup(64'h1C00_0000, 32'd5, 1'b0);
    lookup(64'hBFFF_FFFF, 32'd13, 1'b0);
    lookup(64'hC000_0000, 32'd0, 1'b1);

    cfg(1'b0, 3, 2, '0, 1'b0, 1'b1, 64'd3);
    cfg(1'b0, 13, 3, '0, 1'b0, 1'b1, 64'd1);
    cfg(1'b0, 1, 1, '0, 1'b0, 1'b1, 64'h0002_0000);
    cfg(1'b0, 12, 0, '0, 1'b0, 1'b1, 64'h6000_0000);
    cfg(1'b0, 14, 0, '0, 1'b1, 1'b1, 64'd0);
    cfg(1'b1, 15, 1, 64'h1234, 1'b1, 1'b0, 64'd0);

    // Backpressure: response held while rsp_ready_i is low.
    wait_idle();
    rsp_ready_i = 1'b0;
    rsp_q.push_back('{idx: 32'd13, decerr: 1'b0});
    req_valid_i = 1'b1;
    req_addr_i  = 64'h8000_0000;
    @(posedge clk_i);
    #1;
    rsp_q.push_back('{idx: 32'd10, decerr: 1'b0});
    req_addr_i = 64'h4000_0FFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("hold_valid", 64'(rsp_valid_o), 64'd1);
      check("hold_idx", 64'(rsp_idx_o), 64'd13);
      check("hold_req_ready", 64'(req_ready_o), 64'd0);
    end
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("release_req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;

    // Write in the same cycle as a lookup: lookup sees the old rule.
    wait_idle();
    rsp_q.push_back('{idx: 32'd10, decerr: 1'b0});
    cfg_q.push_back('{err: OverlapChk, chk: 1'b0, rdata: 64'd0});
    cfg_req_i   = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = CfgAW'(10 * 4 + 0);
    cfg_wdata_i = 64'h5000_0000;
    req_valid_i = 1'b1;
    req_addr_i  = 64'h4000_0000;
    @(posedge clk_i);
    #1;
    cfg_req_i   = 1'b0;
    cfg_we_i    = 1'b0;
    req_valid_i = 1'b0;
    lookup(64'h4000_0000, OverlapChk ? 32'd10 : 32'd0, !OverlapChk);
    cfg(1'b0, 10, 0, '0, 1'b0, 1'b1, OverlapChk ? 64'h4000_0000 : 64'h5000_0000);
    wait_idle();
    chk_miss("miss_after_write");

    // Timer start moved past its end.
    cfg(1'b1, 7, 0, 64'h1C00_0000, OverlapChk, 1'b0, 64'd0);
    cfg(1'b0, 7, 0, '0, 1'b0, 1'b1, OverlapChk ? 64'h1800_0000 : 64'h1C00_0000);
    lookup(64'h1C00_0000, 32'd5, 1'b0);
    lookup(64'h1800_0000, OverlapChk ? 32'd7 : 32'd0, !OverlapChk);

    // Overlapping rules: lowest index wins.
    cfg(1'b1, 11, 1, 64'h8000_1000, OverlapChk, 1'b0, 64'd0);
    lookup(64'h8000_0000, OverlapChk ? 32'd13 : 32'd11, 1'b0);
    lookup(64'h6000_0000, OverlapChk ? 32'd12 : 32'd11, 1'b0);
    lookup(64'h8000_1000, 32'd13, 1'b0);

    // Disable rule 13.
    cfg(1'b1, 13, 3, 64'd0, 1'b0, 1'b0, 64'd0);
    cfg(1'b0, 13, 3, '0, 1'b0, 1'b1, 64'd0);
    lookup(64'h9000_0000, 32'd0, 1'b1);

    // Lock: writes dropped, reads still legal.
    @(posedge clk_i);
    #1;
    cfg_lock_i = 1'b1;
    @(posedge clk_i);
    #1;
    cfg_lock_i = 1'b0;
    cfg(1'b1, 1, 1, 64'h0003_0000, 1'b1, 1'b0, 64'd0);
    cfg(1'b0, 1, 1, '0, 1'b0, 1'b1, 64'h0002_0000);

    // Saturating miss counter.
    wait_idle();
    req_valid_i = 1'b1;
    req_addr_i  = 64'hF000_0000;
    for (int i = 0; i < 65540; i++) begin
      rsp_q.push_back('{idx: 32'd0, decerr: 1'b1});
      if (exp_miss < 32'hFFFF) exp_miss++;
      @(posedge clk_i);
    end
    #1;
    req_valid_i = 1'b0;
    wait_idle();
    chk_miss("miss_saturated");

    // Reset with a response pending drops it.
    rsp_ready_i = 1'b0;
    lookup(64'hF000_0000, 32'd0, 1'b1);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rsp_q.delete();
    exp_miss = 0;
    @(negedge clk_i);
    check("rst_drop_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_drop_miss", 64'(miss_cnt_o), 64'd0);
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b1;

    // Lock cleared by reset; default rule restored.
    cfg(1'b0, 1, 1, '0, 1'b0, 1'b1, 64'h0002_0000);
    cfg(1'b1, 1, 1, 64'h0003_0000, 1'b0, 1'b0, 64'd0);
    cfg(1'b0, 1, 1, '0, 1'b0, 1'b1, 64'h0003_0000);
    lookup(64'h4000_0000, 32'd10, 1'b0);

    for (int n = 0; n < 20 && (rsp_q.size() != 0 || cfg_q.size() != 0); n++) begin
      @(posedge clk_i);
    end
    #1;
    check("drain_rsp_q", 64'(rsp_q.size()), 64'd0);
    check("drain_cfg_q", 64'(cfg_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
